// File: rtl/ram_port_arbiter.sv
// Two-client arbiter for an 8x10 dual-port RAM: independent round-robin write/read ports, clear sequencing.
// Optional per-client grant counters are enabled with `define ARB_GNT_CNT_EN.
module ram_port_arbiter #(
   parameter int DATA_W = 10,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_req,
   input  logic              c0_wr_req,
   input  logic              c1_wr_req,
   input  logic [ADDR_W-1:0] c0_wr_addr,
   input  logic [ADDR_W-1:0] c1_wr_addr,
   input  logic [DATA_W-1:0] c0_wr_data,
   input  logic [DATA_W-1:0] c1_wr_data,
   input  logic              c0_rd_req,
   input  logic              c1_rd_req,
   input  logic [ADDR_W-1:0] c0_rd_addr,
   input  logic [ADDR_W-1:0] c1_rd_addr,
   output logic              c0_wr_gnt,
   output logic              c1_wr_gnt,
   output logic              c0_rd_gnt,
   output logic              c1_rd_gnt,
   output logic              c0_rvalid,
   output logic              c1_rvalid,
   output logic [DATA_W-1:0] c0_rdata,
   output logic [DATA_W-1:0] c1_rdata,
   output logic              busy,
   output logic [DATA_W-1:0] ram_data,
   output logic [ADDR_W-1:0] ram_addr_wa,
   output logic [ADDR_W-1:0] ram_addr_ra,
   output logic              ram_we,
   output logic              ram_re,
   output logic [3:0]        ram_state,
`ifdef ARB_GNT_CNT_EN
   output logic [7:0]        c0_gnt_cnt,
   output logic [7:0]        c1_gnt_cnt,
`endif
   input  logic [DATA_W-1:0] ram_q
);

   typedef enum logic [0:0] {
      S_CLEAR = 1'b0,
      S_RUN   = 1'b1
   } state_t;

   state_t r_state;
   state_t w_next;

   logic w_run;
   logic r_wr_last;
   logic r_rd_last;
   logic r_c0_rvalid;
   logic r_c1_rvalid;
   logic w_c0_wg;
   logic w_c1_wg;
   logic w_c0_rg;
   logic w_c1_rg;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_CLEAR;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_run     = 1'b0;
      busy      = 1'b1;
      ram_state = 4'b0001;
      unique case (r_state)
         S_CLEAR: begin
            if (!clr_req) w_next = S_RUN;
         end
         S_RUN: begin
            w_run     = 1'b1;
            busy      = 1'b0;
            ram_state = 4'b0010;
            if (clr_req) w_next = S_CLEAR;
         end
         default: w_next = S_CLEAR;
      endcase
   end

   // last pointer: 1 means c1 won the previous grant, so c0 wins a tie
   always_comb begin
      w_c0_wg = w_run & c0_wr_req & (~c1_wr_req | r_wr_last);
      w_c1_wg = w_run & c1_wr_req & (~c0_wr_req | ~r_wr_last);
      w_c0_rg = w_run & c0_rd_req & (~c1_rd_req | r_rd_last);
      w_c1_rg = w_run & c1_rd_req & (~c0_rd_req | ~r_rd_last);
   end

   assign c0_wr_gnt = w_c0_wg;
   assign c1_wr_gnt = w_c1_wg;
   assign c0_rd_gnt = w_c0_rg;
   assign c1_rd_gnt = w_c1_rg;
   assign ram_we    = w_c0_wg | w_c1_wg;
   assign ram_re    = w_c0_rg | w_c1_rg;

   always_comb begin
      ram_addr_wa = '0;
      ram_data    = '0;
      ram_addr_ra = '0;
      unique case (1'b1)
         w_c0_wg: begin
            ram_addr_wa = c0_wr_addr;
            ram_data    = c0_wr_data;
         end
         w_c1_wg: begin
            ram_addr_wa = c1_wr_addr;
            ram_data    = c1_wr_data;
         end
         default: ;
      endcase
      unique case (1'b1)
         w_c0_rg: ram_addr_ra = c0_rd_addr;
         w_c1_rg: ram_addr_ra = c1_rd_addr;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_last <= 1'b1;
         r_rd_last <= 1'b1;
      end else begin
         if (ram_we) r_wr_last <= w_c1_wg;
         if (ram_re) r_rd_last <= w_c1_rg;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_c0_rvalid <= 1'b0;
         r_c1_rvalid <= 1'b0;
      end else begin
         r_c0_rvalid <= w_c0_rg;
         r_c1_rvalid <= w_c1_rg;
      end
   end

   assign c0_rvalid = r_c0_rvalid;
   assign c1_rvalid = r_c1_rvalid;
   assign c0_rdata  = r_c0_rvalid ? ram_q : '0;
   assign c1_rdata  = r_c1_rvalid ? ram_q : '0;

`ifdef ARB_GNT_CNT_EN
   logic [7:0] r_c0_cnt;
   logic [7:0] r_c1_cnt;
   logic       w_c0_any;
   logic       w_c1_any;

   assign w_c0_any = w_c0_wg | w_c0_rg;
   assign w_c1_any = w_c1_wg | w_c1_rg;

   // counters saturate and are wiped on every clear cycle
   always_ff @(posedge clk) begin
      if (rst || r_state == S_CLEAR) begin
         r_c0_cnt <= '0;
         r_c1_cnt <= '0;
      end else begin
         if (w_c0_any && r_c0_cnt != 8'hFF) r_c0_cnt <= r_c0_cnt + 8'd1;
         if (w_c1_any && r_c1_cnt != 8'hFF) r_c1_cnt <= r_c1_cnt + 8'd1;
      end
   end

   assign c0_gnt_cnt = r_c0_cnt;
   assign c1_gnt_cnt = r_c1_cnt;
`endif

endmodule
